// File: rtl/addsub_seq.sv
// ---------------------------------------------------------------------------
// addsub_seq -- multi-cycle add/subtract unit.
//
// Purpose:
//   Computes A+B or A-B on WIDTH-bit operands using a single SEG-bit ripple
//   segment, processing one segment per clock (N = WIDTH/SEG cycles) with a
//   registered inter-segment carry. Carry, signed-overflow and zero flags are
//   returned alongside the result.
//
// Optional feature (compile-time macro):
//   ADDSUB_SAT_EN  -- adds the 'sat' input. When the registered sat bit is set
//                     and the operation overflows, the result is clamped to the
//                     signed limit in the direction of A's sign.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  block can accept operands (high only in IDLE)
//   a, b       in   WIDTH-bit operands
//   sub        in   0: A+B, 1: A-B
//   sat        in   saturate on signed overflow (ADDSUB_SAT_EN only)
//   out_valid  out  result valid (high only in DONE)
//   out_ready  in   consumer accepts result
//   result     out  WIDTH-bit sum/difference
//   cout       out  carry out of MSB (subtract: 1 = no borrow)
//   ovf        out  signed two's-complement overflow
//   zero       out  result == 0, after any saturation
//   dbg_state  out  current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready does not depend on in_valid, out_valid does not depend
// on out_ready, and the producer holds data stable while valid is high and
// ready is low. Operands need not be held after their transfer edge.
// ---------------------------------------------------------------------------
module addsub_seq #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / SEG;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    generate
        if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
            $error("addsub_seq: WIDTH must be a positive multiple of SEG");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;      // already inverted for subtract
    logic              carry;
`ifdef ADDSUB_SAT_EN
    logic              sat_r;
`endif

    logic              last;
    logic [SEG-1:0]    a_seg;
    logic [SEG-1:0]    b_seg;
    logic [SEG:0]      seg_sum;
    logic              c_msb;
    logic              ovf_nxt;
    logic [WIDTH-1:0]  res_wr;
    logic [WIDTH-1:0]  res_fin;

    assign last      = (k == K_LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Segment datapath: select segment k, add with carry, and splice the
    // segment sum back into a copy of the result register.
    always_comb begin
        a_seg  = '0;
        b_seg  = '0;
        res_wr = result;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                a_seg = a_r[i*SEG +: SEG];
                b_seg = b_r[i*SEG +: SEG];
            end
        end

        seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, carry};

        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                res_wr[i*SEG +: SEG] = seg_sum[SEG-1:0];
            end
        end

        // Carry into the top bit of this segment; only meaningful when k is
        // the last segment, where it feeds the overflow flag.
        c_msb   = seg_sum[SEG-1] ^ a_seg[SEG-1] ^ b_seg[SEG-1];
        ovf_nxt = c_msb ^ seg_sum[SEG];

        res_fin = res_wr;
`ifdef ADDSUB_SAT_EN
        // Overflow always pushes the result away from A's sign, so A's MSB
        // selects which limit to clamp to.
        if (sat_r && ovf_nxt) begin
            res_fin = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            k      <= '0;
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
`ifdef ADDSUB_SAT_EN
            sat_r  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        // Subtract as A + ~B + 1: the +1 enters via the carry.
                        b_r   <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        k     <= '0;
`ifdef ADDSUB_SAT_EN
                        sat_r <= sat;
`endif
                    end
                end
                BUSY: begin
                    carry <= seg_sum[SEG];
                    if (last) begin
                        k      <= '0;
                        result <= res_fin;
                        cout   <= seg_sum[SEG];
                        ovf    <= ovf_nxt;
                        zero   <= (res_fin == '0);
                    end else begin
                        k      <= k + 1'b1;
                        result <= res_wr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
